// File: rtl/seq_pkg.sv
// Shared types and constants for the exhaustive vector sequencer.
// The signature path (seq_misr) is only built when SEQ_SIGNATURE_EN is defined.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCapture,
        StEmit,
        StDone
    } seq_state_e;

    localparam logic [31:0] MisrPoly = 32'h04C1_1DB7;
    localparam logic [31:0] MisrSeed = 32'hFFFF_FFFF;

    // Widest record the sequencer can produce; instances use the low bits.
    localparam int unsigned RecVecW  = 16;
    localparam int unsigned RecRespW = 32;

    typedef struct packed {
        logic [RecVecW-1:0]  vec;
        logic [RecRespW-1:0] resp;
        logic                last;
    } seq_rec_t;

    // One MISR step: shift left, fold in the polynomial on carry-out, xor the data word.
    function automatic logic [31:0] misr_step(input logic [31:0] cur, input logic [31:0] data);
        return {cur[30:0], 1'b0} ^ (cur[31] ? MisrPoly : 32'h0) ^ data;
    endfunction

endpackage

// File: rtl/seq_misr.sv
// 32-bit multiple-input signature register. clear reseeds, enable folds in data.
module seq_misr
    import seq_pkg::*;
(
    input  logic        CK,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    logic [31:0] sig_q;
    logic [31:0] sig_d;

    // Next signature: clear wins over enable.
    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = MisrSeed;
        end else if (enable) begin
            sig_d = misr_step(sig_q, data);
        end
    end

    // Signature register.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig_q <= MisrSeed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive stimulus sequencer: walks vec_out through 0..2^N_IN-1, waits SETTLE cycles per
// vector, samples resp_in and offers {vector, response} records on a valid/ready handshake.
// Optional: SEQ_SIGNATURE_EN adds a MISR over accepted responses and the sig output.
module exhaustive_vector_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned N_IN   = 5,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned SETTLE = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] resp_in,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_vec,
    output logic [N_OUT-1:0] rec_resp,
    output logic             rec_last,
    output logic             busy,
    output logic             done
`ifdef SEQ_SIGNATURE_EN
    ,
    output logic [31:0]      sig
`endif
);

    localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

    seq_state_e       state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [N_IN-1:0]  rvec_q, rvec_d;
    logic [N_OUT-1:0] rresp_q, rresp_d;
    logic             rlast_q, rlast_d;

    // Next-state and datapath updates; abort freezes the datapath and forces IDLE.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        rvec_d  = rvec_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StCapture: begin
                rvec_d  = vec_q;
                rresp_d = resp_in;
                rlast_d = (vec_q == '1);
                state_d = StEmit;
            end
            StEmit: begin
                if (rec_ready) begin
                    if (rlast_q) begin
                        state_d = StDone;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = '0;
                        state_d = StSettle;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (abort) begin
            state_d = StIdle;
            vec_d   = vec_q;
            cnt_d   = cnt_q;
            rvec_d  = rvec_q;
            rresp_d = rresp_q;
            rlast_d = rlast_q;
        end
    end

    // State and record registers.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            vec_q   <= '0;
            cnt_q   <= '0;
            rvec_q  <= '0;
            rresp_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            rvec_q  <= rvec_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

    // Outputs decode from registered state only, so rec_ready never reaches them directly.
    assign vec_out   = vec_q;
    assign rec_vec   = rvec_q;
    assign rec_resp  = rresp_q;
    assign rec_last  = rlast_q;
    assign rec_valid = (state_q == StEmit);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

`ifdef SEQ_SIGNATURE_EN
    logic        misr_clear;
    logic        misr_en;
    logic [31:0] misr_data;

    assign misr_clear = (state_q == StIdle) && start && !abort;
    assign misr_en    = (state_q == StEmit) && rec_ready && !abort;

    // Zero-extend the accepted response to the MISR width.
    always_comb begin
        misr_data            = '0;
        misr_data[N_OUT-1:0] = rresp_q;
    end

    seq_misr u_misr (
        .CK     (CK),
        .reset  (reset),
        .clear  (misr_clear),
        .enable (misr_en),
        .data   (misr_data),
        .sig    (sig)
    );
`endif

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Directed self-checking bench for exhaustive_vector_sequencer (N_IN=5, N_OUT=1, SETTLE=1).
// Build with SEQ_SIGNATURE_EN defined to also exercise the sig output.
module tb_exhaustive_vector_sequencer;

    localparam int unsigned N_IN   = 5;
    localparam int unsigned N_OUT  = 1;
    localparam int unsigned SETTLE = 1;
    localparam int unsigned NVEC   = 32;

    logic CK = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic rec_ready = 1'b1;
    logic [N_IN-1:0]  vec_out;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] resp_in;
    logic [N_OUT-1:0] rec_resp;
    logic rec_valid, rec_last, busy, done;
`ifdef SEQ_SIGNATURE_EN
    logic [31:0] sig;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int vcnt = 0;
    logic resp_mode = 1'b0;
    logic bp_en = 1'b0;
    // Parity of 0..31, bit i = ^i, worked out by hand: 0x6996 for 0..15, complemented above.
    logic [31:0] parity_tbl = 32'h9669_6996;

    logic [N_IN+N_OUT:0] rec_q[$];
    logic held = 1'b0;
    logic [N_IN-1:0]  h_vec;
    logic [N_OUT-1:0] h_resp;
    logic             h_last;

    exhaustive_vector_sequencer #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .SETTLE (SETTLE)
    ) dut (
        .CK        (CK),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .vec_out   (vec_out),
        .resp_in   (resp_in),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_vec   (rec_vec),
        .rec_resp  (rec_resp),
        .rec_last  (rec_last),
        .busy      (busy),
        .done      (done)
`ifdef SEQ_SIGNATURE_EN
        ,
        .sig       (sig)
`endif
    );

    always #5 CK = ~CK;

    // Benchmark under test: parity of the vector, or vec[0] in signature mode.
    assign resp_in = resp_mode ? vec_out[0] : ^vec_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Logger side: back-pressure holds ready low for the first 3 cycles of every record.
    always @(posedge CK) begin
        #1;
        if (rec_valid) vcnt++;
        else vcnt = 0;
        rec_ready = !bp_en || (vcnt >= 4);
    end

    // Record monitor: collects accepted records and checks held records stay stable.
    always @(negedge CK) begin
        if (done) done_cnt++;
        if (rec_valid) begin
            if (held) begin
                check("hold_vec", 32'(rec_vec), 32'(h_vec));
                check("hold_resp", 32'(rec_resp), 32'(h_resp));
                check("hold_last", 32'(rec_last), 32'(h_last));
            end
            if (rec_ready) begin
                rec_q.push_back({rec_last, rec_resp, rec_vec});
                held = 1'b0;
            end else begin
                held   = 1'b1;
                h_vec  = rec_vec;
                h_resp = rec_resp;
                h_last = rec_last;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic check_reset(input string name);
        check({name, "_vec_out"}, 32'(vec_out), 32'd0);
        check({name, "_rec_vec"}, 32'(rec_vec), 32'd0);
        check({name, "_rec_resp"}, 32'(rec_resp), 32'd0);
        check({name, "_rec_valid"}, 32'(rec_valid), 32'd0);
        check({name, "_rec_last"}, 32'(rec_last), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
`ifdef SEQ_SIGNATURE_EN
        check({name, "_sig"}, sig, 32'hFFFF_FFFF);
`endif
    endtask

    // Pulse start, count edges (start edge = 1) until done, then check every record.
    task automatic run_sweep(input string name, input int exp_cycles);
        int cyc;
        logic [N_IN+N_OUT:0] r;
        logic exp_resp;
        rec_q.delete();
        @(posedge CK); #1 start = 1'b1;
        @(posedge CK); #1 start = 1'b0;
        cyc = 1;
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_vec0"}, 32'(vec_out), 32'd0);
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge CK); #1;
            cyc++;
        end
        check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({name, "_count"}, 32'(rec_q.size()), 32'(NVEC));
        for (int i = 0; i < rec_q.size() && i < int'(NVEC); i++) begin
            r = rec_q[i];
            exp_resp = resp_mode ? i[0] : parity_tbl[i];
            check($sformatf("%s_vec%0d", name, i), 32'(r[N_IN-1:0]), 32'(i));
            check($sformatf("%s_resp%0d", name, i), 32'(r[N_IN+N_OUT-1:N_IN]), 32'(exp_resp));
            check($sformatf("%s_last%0d", name, i), 32'(r[N_IN+N_OUT]), 32'(i == 31));
        end
        @(posedge CK); #1;
        check({name, "_done_1cyc"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_vec_kept"}, 32'(vec_out), 32'd31);
    endtask

    function automatic logic [31:0] ref_sig();
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        for (int i = 0; i < int'(NVEC); i++) begin
            m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C1_1DB7 : 32'h0) ^ {31'b0, i[0]};
        end
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int guard;
        repeat (3) @(posedge CK);
        #1 check_reset("rst");
        @(negedge CK) reset = 1'b1;
        @(posedge CK); #1;
        check_reset("post_rst");

        // Baseline: 32 * (SETTLE+2) + 1 = 97.
        run_sweep("base", 97);

        // start pulses while busy must not disturb the sweep.
        fork
            run_sweep("busy_start", 97);
            begin
                repeat (20) @(posedge CK);
                #1 start = 1'b1;
                @(posedge CK); #1 start = 1'b0;
                repeat (30) @(posedge CK);
                #1 start = 1'b1;
                @(posedge CK); #1 start = 1'b0;
            end
        join

        // start and abort together in IDLE: stays idle, vec_out untouched.
        dc = done_cnt;
        @(posedge CK); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge CK); #1 begin start = 1'b0; abort = 1'b0; end
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_vec_kept", 32'(vec_out), 32'd31);
        repeat (3) @(posedge CK);
        #1;
        check("sa_still_idle", 32'(busy), 32'd0);
        check("sa_no_done", 32'(done_cnt), 32'(dc));

        // Back-pressure: 32 * (1 + 1 + 4) + 1 = 193.
        bp_en = 1'b1;
        run_sweep("bp", 193);
        bp_en = 1'b0;

        // Abort during EMIT of vector 12.
        @(posedge CK); #1 start = 1'b1;
        @(posedge CK); #1 start = 1'b0;
        guard = 0;
        while (!(rec_valid === 1'b1 && rec_vec == 5'd12) && guard < 500) begin
            @(posedge CK); #1;
            guard++;
        end
        check("ab_reached12", 32'(rec_valid && rec_vec == 5'd12), 32'd1);
        dc = done_cnt;
        abort = 1'b1;
        @(posedge CK); #1 abort = 1'b0;
        check("ab_valid_drop", 32'(rec_valid), 32'd0);
        check("ab_idle", 32'(busy), 32'd0);
        check("ab_vec_kept", 32'(vec_out), 32'd12);
        repeat (5) @(posedge CK);
        #1;
        check("ab_no_done", 32'(done_cnt), 32'(dc));
        check("ab_still_idle", 32'(busy), 32'd0);
        run_sweep("after_abort", 97);

        // Asynchronous reset during SETTLE of vector 20.
        @(posedge CK); #1 start = 1'b1;
        @(posedge CK); #1 start = 1'b0;
        guard = 0;
        while (vec_out != 5'd20 && guard < 500) begin
            @(posedge CK); #1;
            guard++;
        end
        check("rs_reached20", 32'(vec_out), 32'd20);
        dc = done_cnt;
        #2 reset = 1'b0;
        #1 check_reset("mid_rst");
        #3 reset = 1'b1;
        @(posedge CK); #1;
        check("rs_idle", 32'(busy), 32'd0);
        check("rs_no_done", 32'(done_cnt), 32'(dc));
        run_sweep("after_reset", 97);

`ifdef SEQ_SIGNATURE_EN
        resp_mode = 1'b1;
        run_sweep("sig1", 97);
        check("sig_first", sig, ref_sig());
        repeat (4) @(posedge CK);
        #1 check("sig_held", sig, ref_sig());
        run_sweep("sig2", 97);
        check("sig_repeat", sig, ref_sig());
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
